// File: rtl/divider.sv
// Iterative restoring divider, signed/unsigned: result {rem, quo} after 34 edges (2 for a zero divisor).
// No backpressure: ready_o holds the result until start_i drops; annul_i aborts an unfinished divide.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial;
  logic               fits;
  logic [WIDTH-1:0]   op1_mag, op2_mag, q_mag, r_mag;

  always_comb begin
    op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Upper WIDTH+1 bits hold the partial remainder, lower WIDTH bits shift
    // dividend out and quotient bits in.
    shifted = {rem_q[2*WIDTH-1:0], 1'b0};
    fits    = shifted[2*WIDTH:WIDTH] >= {1'b0, div_q};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, div_q};
    q_mag   = rem_q[WIDTH-1:0];
    r_mag   = rem_q[2*WIDTH-1:WIDTH];

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            cnt_d   = '0;
            rem_d   = {{(WIDTH+1){1'b0}}, op1_mag};
            div_d   = op2_mag;
            qneg_d  = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rneg_d  = signed_div_i && opdata1_i[WIDTH-1];
          end
        end
      end
      BYZERO: begin
        state_d  = annul_i ? FREE : END;
        ready_d  = !annul_i;
        result_d = '0;
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = {rneg_q ? -r_mag : r_mag, qneg_q ? -q_mag : q_mag};
        end else begin
          rem_d = fits ? {trial, shifted[WIDTH-1:1], 1'b1} : shifted;
          cnt_d = cnt_q + 1'b1;
        end
      end
      END: begin
        if (!start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d  = FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != FREE);

endmodule

// File: tb/tb_divider.sv
// Bench for divider: directed vector table, corner-case sequences, random operands vs arithmetic model.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  divider #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Reference from plain arithmetic: SV integer division truncates toward zero.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Wait up to a bound for ready_o; n returns the edge count (bound on timeout).
  task automatic wait_ready(output int n, output logic busy_first);
    bit got;
    got = 1'b0;
    n = 0;
    busy_first = 1'b0;
    while (n < 60 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        busy_first = busy_o;
        // Scramble operands after acceptance; the result must not change.
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~signed_div_i;
      end
      if (ready_o) got = 1'b1;
    end
  endtask

  task automatic do_div(input string nm, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int   n;
    logic bz;
    start_i = 1'b1; signed_div_i = sgn; opdata1_i = a; opdata2_i = b; annul_i = 1'b0;
    wait_ready(n, bz);
    chk({nm, " latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
    chk({nm, " result"}, result_o, exp);
    chk({nm, " busy_edge1"}, 64'(bz), 64'd1);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({nm, " ready_drop"}, 64'(ready_o), 64'd0);
    chk({nm, " result_clr"}, result_o, 64'd0);
    chk({nm, " busy_clr"}, 64'(busy_o), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int   n;
    logic bz;
    logic [31:0] a, b;
    bit   sgn;

    vecs.push_back('{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD});
    vecs.push_back('{1'b0, 32'h12345678,   32'd0,        64'h0});
    vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003});
    vecs.push_back('{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC});
    vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF});
    vecs.push_back('{1'b0, 32'd5,          32'd10,       64'h00000005_00000000});

    rst = 1'b1; start_i = 1'b0; signed_div_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) do_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Annul during the 10th step (11th edge), then a clean 9/3.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul busy", 64'(busy_o), 64'd0);
    chk("annul result", result_o, 64'd0);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) n++;
    end
    chk("annul no_ready", 64'(n), 64'd0);
    do_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Annul together with start in FREE must not start.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("annul_free busy", 64'(busy_o), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;

    // Annul in BYZERO.
    start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
    @(posedge clk); #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_byzero ready", 64'(ready_o), 64'd0);
    chk("annul_byzero busy", 64'(busy_o), 64'd0);

    // Annul in END is ignored while start_i stays high.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    wait_ready(n, bz);
    chk("end_annul latency", 64'(n), 64'd34);
    annul_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("end_annul ready", 64'(ready_o), 64'd1);
    chk("end_annul result", result_o, 64'h00000000_00000003);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    chk("end_annul drop", 64'(ready_o), 64'd0);

    // Reset at step 20, then a normal request.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset ready", 64'(ready_o), 64'd0);
    chk("midreset result", result_o, 64'd0);
    chk("midreset busy", 64'(busy_o), 64'd0);
    do_div("after_reset", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Random operands against the arithmetic model.
    for (int k = 0; k < 24; k++) begin
      sgn = $urandom_range(0, 1);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_div($sformatf("rand%0d", k), sgn, a, b, ref_div(sgn, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand width in bits; only 32 is supported.
REQ-002 The module SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The module SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The module SHALL have port start_i, input, 1, divide request; held high by the issuer until ready_o is seen.
REQ-005 The module SHALL have port signed_div_i, input, 1, 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-006 The module SHALL have port opdata1_i, input, 32, dividend.
REQ-007 The module SHALL have port opdata2_i, input, 32, divisor.
REQ-008 The module SHALL have port annul_i, input, 1, abort the division in progress.
REQ-009 The module SHALL have port result_o, output, 64, {remainder[63:32] (HI), quotient[31:0] (LO)}.
REQ-010 The module SHALL have port ready_o, output, 1, result_o valid.
REQ-011 The module SHALL have port busy_o, output, 1, high in any state other than FREE; drives the CTRL stall request.

Function
REQ-012 The module SHALL implement four states: FREE, BYZERO, ON, END.
REQ-013 In FREE, start_i=1, annul_i=0 and opdata2_i!=0: the module SHALL capture the operands and signed_div_i, load the iteration counter with 0, and go to ON.
REQ-014 In FREE, start_i=1, annul_i=0 and opdata2_i==0: the module SHALL go to BYZERO.
REQ-015 In BYZERO, the module SHALL go to END with result 64'h0 on the next edge.
REQ-016 In signed mode, the datapath SHALL operate on two's-complement magnitudes of both operands; in unsigned mode it SHALL use the raw operands.
REQ-017 ON SHALL perform one restoring shift-subtract step per edge on a 65-bit partial-remainder register.
REQ-018 After 32 steps the module SHALL go to END.
REQ-019 The quotient SHALL be negated when signed mode is set and the operand signs differ.
REQ-020 The remainder SHALL be negated when signed mode is set and the dividend is negative.
REQ-021 In signed mode, 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 with no exception.
REQ-022 In END, result_o SHALL hold the final value and ready_o SHALL be 1.
REQ-023 The module SHALL remain in END until start_i=0, then go to FREE with ready_o=0 and result_o=0.
REQ-024 Latency, nonzero divisor: ready_o SHALL first be 1 after the 34th rising edge counted from the edge that sampled start_i in FREE (1 accept edge + 32 steps + 1 finalise edge).
REQ-025 Latency, zero divisor: ready_o SHALL first be 1 after the 2nd edge.
REQ-026 annul_i=1 in ON or BYZERO SHALL return the module to FREE on the next edge with ready_o=0 and result_o=0.
REQ-027 annul_i=1 in END SHALL NOT take effect; leaving END is controlled by start_i only.
REQ-028 annul_i=1 together with start_i in FREE SHALL NOT start a division.
REQ-029 Operand changes after acceptance SHALL NOT affect the result.
REQ-030 start_i SHALL be ignored outside FREE.
REQ-031 ready_o and result_o SHALL be registered outputs.
REQ-032 ready_o SHALL be 0 in every state except END.

Reset
REQ-033 On rst=1 at a clock edge, the module SHALL enter FREE.
REQ-034 Reset SHALL clear result_o to 64'h0, ready_o to 0, busy_o to 0, the counter to 0 and the partial remainder to 0.
REQ-035 Reset SHALL override every state and input, including a division in progress.
REQ-036 After reset is released, the next start_i SHALL be accepted normally.

Verification
REQ-037 Unsigned: opdata1=100, opdata2=7, signed=0 -> result_o=64'h00000002_0000000E; ready_o rises after edge 34; busy_o high from edge 1.
REQ-038 Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2 -> result_o=64'hFFFFFFFF_FFFFFFFD (r=-1, q=-3).
REQ-039 Divide by zero: opdata1=0x12345678, opdata2=0 -> ready_o after edge 2, result_o=0.
REQ-040 Signed overflow: 0x80000000 / 0xFFFFFFFF -> result_o=64'h00000000_80000000.
REQ-041 Annul: annul_i=1 during the 10th step -> FREE next edge, ready_o never asserted; a following 9/3 request returns 64'h0_00000003.
REQ-042 Reset mid-operation: rst at step 20 -> all outputs 0 and state FREE; held start_i=0 in END -> ready_o falls the next edge.
